lu_arbiter: RTL and testbench
=============================

LU_ARBITER -- requirements
Module: lu_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with requester 0 winning.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  in  1  request present.
REQ-005 SHALL have ports req0_ready/req1_ready  out  1  request accepted this cycle when high together with valid.
REQ-006 SHALL have ports req0_a/req1_a and req0_b/req1_b  in  16 each  operands.
REQ-007 SHALL have ports req0_op/req1_op  in  3  logic-unit opcode; all 8 codes are legal.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid  out  1  result available.
REQ-009 SHALL have ports rsp0_ready/rsp1_ready  in  1  requester takes the result.
REQ-010 SHALL have ports rsp0_data/rsp1_data  out  32  captured outlu.
REQ-011 SHALL have ports rsp0_flags/rsp1_flags  out  5  captured {za,zb,eq,gt,lt}, za at MSB.
REQ-012 SHALL have ports lu_a, lu_b  out  16 each, and lu_opcode  out  3; these drive the shared logic unit.
REQ-013 SHALL have ports lu_outlu  in  32 and lu_za, lu_zb, lu_eq, lu_gt, lu_lt  in  1 each; these come from the shared logic unit.
REQ-014 SHALL have port busy  out  1, high whenever the FSM is not in IDLE.
REQ-015 SHALL have port op_count  out  16, the number of completed operations.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 SHALL, in IDLE only, drive at most one reqN_ready high: the granted requester whose valid is high. Ready is combinational from state, valids and pointer.
REQ-018 SHALL, in round-robin mode with both valid, grant the requester not served last (last_grant register).
REQ-019 SHALL, when only one requester is valid, grant that requester regardless of mode.
REQ-020 SHALL, on accept (valid & ready in IDLE): register a, b, op onto lu_a, lu_b, lu_opcode; record the grant id; go to EXEC.
REQ-021 SHALL, in EXEC (one cycle), capture lu_outlu and the five flags into the result registers and go to RESP; lu_* outputs stay stable through EXEC and RESP.
REQ-022 SHALL, in RESP, hold rspN_valid high for the granted id only, with data/flags stable, until rspN_ready is high.
REQ-023 SHALL, on the rspN_ready handshake: go to IDLE; update last_grant to the served id; increment op_count modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-024 SHALL give accept at edge T, rsp valid from cycle T+2; minimum spacing between accepts is 3 cycles.
REQ-025 SHALL deassert both reqN_ready in EXEC and RESP; new requests wait and are never dropped or reordered within one requester.
REQ-026 SHALL ignore rspN_ready while rspN_valid is low.
REQ-027 SHALL keep rspN_data/rspN_flags holding the last captured values when valid is low; the non-granted response port carries 0.
REQ-028 SHALL, in fixed-priority mode, grant requester 0 whenever req0_valid is high; requester 1 may starve.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear: state to IDLE; lu_a, lu_b, lu_opcode to 0; result registers to 0; rsp valids to 0; busy to 0; op_count to 0; last_grant to 1 (requester 0 wins the first tie).
REQ-030 SHALL, on rst asserted mid-operation (EXEC or RESP), discard the in-flight result without a response and without counting it.
REQ-031 SHALL hold both reqN_ready low during any cycle in which rst is high.

Verification
REQ-032 Single request: req0 a=0x0009, b=0x0005, op=0 -> ready in the same cycle; rsp0_valid 2 cycles later; flags=00010 (gt); op_count=1.
REQ-033 Simultaneous requests after reset: req0 a=0x0003, b=0x000F; req1 a=0x00E9, b=0x00E9 -> req0 served first with flags 00001 (lt); then req1 served with flags 00100 (eq); last_grant ends at 1.
REQ-034 Backpressure: hold rsp1_ready low 5 cycles with both requesters valid -> rsp1_valid, data and flags stay stable; req0_ready stays 0 throughout; req0 accepted the cycle after IDLE is re-entered.
REQ-035 Zero flags: a=0x0000, b=0x0000 -> flags 11100 (za, zb, eq); with b=0x0005 -> flags 10001 (za, lt).
REQ-036 Reset mid-RESP: rst for 1 cycle while rsp0_valid is high -> rsp0_valid=0 next cycle; op_count=0; busy=0; a subsequent request completes normally.
REQ-037 ARB_MODE=1 with both valid continuously for 4 operations -> all 4 grants go to requester 0; op_count wraps from 0xFFFF to 0x0000 when preloaded via 0xFFFF completed operations (long test).

Source files
------------

// File: rtl/lu_arbiter.sv
// Two-requester front end for one shared logic unit: accept, one EXEC cycle, then hold the result.
// Latency: accept at edge T, response valid from T+2; requesters stall (ready low) until the response is taken.
module lu_arbiter #(
   parameter int unsigned  ARB_MODE  = 0,
   parameter logic [15:0]  OPCNT_RST = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [2:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic [2:0]  req1_op,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,
   output logic [4:0]  rsp0_flags,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data,
   output logic [4:0]  rsp1_flags,
   output logic [15:0] lu_a,
   output logic [15:0] lu_b,
   output logic [2:0]  lu_opcode,
   input  logic [31:0] lu_outlu,
   input  logic        lu_za,
   input  logic        lu_zb,
   input  logic        lu_eq,
   input  logic        lu_gt,
   input  logic        lu_lt,
   output logic        busy,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q;
   logic        last_grant_q;
   logic        gnt_id_q;
   logic        busy_q;
   logic [15:0] lu_a_q;
   logic [15:0] lu_b_q;
   logic [2:0]  lu_op_q;
   logic [31:0] rsp0_dat_q;
   logic [31:0] rsp1_dat_q;
   logic [4:0]  rsp0_flg_q;
   logic [4:0]  rsp1_flg_q;
   logic [1:0]  rsp_vld_q;
   logic [15:0] op_count_q;

   logic        sel_d;
   logic        accept_d;
   logic        rsp_hs_d;
   logic [15:0] a_d;
   logic [15:0] b_d;
   logic [2:0]  op_d;
   logic [4:0]  flg_d;

   // Winner among the valid requesters; only meaningful when at least one is valid.
   always_comb begin
      sel_d = 1'b0;
      if (req0_valid && req1_valid) begin
         sel_d = (ARB_MODE == 1) ? 1'b0 : ~last_grant_q;
      end else if (req1_valid) begin
         sel_d = 1'b1;
      end
   end

   assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !sel_d;
   assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  sel_d;
   assign accept_d   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign rsp_hs_d   = (rsp_vld_q[0] && rsp0_ready) || (rsp_vld_q[1] && rsp1_ready);

   assign a_d   = sel_d ? req1_a  : req0_a;
   assign b_d   = sel_d ? req1_b  : req0_b;
   assign op_d  = sel_d ? req1_op : req0_op;
   assign flg_d = {lu_za, lu_zb, lu_eq, lu_gt, lu_lt};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gnt_id_q     <= 1'b0;
         busy_q       <= 1'b0;
         lu_a_q       <= '0;
         lu_b_q       <= '0;
         lu_op_q      <= '0;
         rsp0_dat_q   <= '0;
         rsp1_dat_q   <= '0;
         rsp0_flg_q   <= '0;
         rsp1_flg_q   <= '0;
         rsp_vld_q    <= '0;
         op_count_q   <= OPCNT_RST;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  lu_a_q   <= a_d;
                  lu_b_q   <= b_d;
                  lu_op_q  <= op_d;
                  gnt_id_q <= sel_d;
                  busy_q   <= 1'b1;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               // The non-granted port is cleared so it never shows a stale result.
               rsp0_dat_q <= gnt_id_q ? 32'h0 : lu_outlu;
               rsp0_flg_q <= gnt_id_q ? 5'h0  : flg_d;
               rsp1_dat_q <= gnt_id_q ? lu_outlu : 32'h0;
               rsp1_flg_q <= gnt_id_q ? flg_d    : 5'h0;
               rsp_vld_q  <= gnt_id_q ? 2'b10 : 2'b01;
               state_q    <= RESP;
            end
            RESP: begin
               if (rsp_hs_d) begin
                  rsp_vld_q    <= 2'b00;
                  last_grant_q <= gnt_id_q;
                  op_count_q   <= op_count_q + 16'd1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign lu_a       = lu_a_q;
   assign lu_b       = lu_b_q;
   assign lu_opcode  = lu_op_q;
   assign rsp0_valid = rsp_vld_q[0];
   assign rsp1_valid = rsp_vld_q[1];
   assign rsp0_data  = rsp0_dat_q;
   assign rsp1_data  = rsp1_dat_q;
   assign rsp0_flags = rsp0_flg_q;
   assign rsp1_flags = rsp1_flg_q;
   assign busy       = busy_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed bench for lu_arbiter: a round-robin instance plus a fixed-priority instance
// whose op_count reset value sits just below the wrap point.
module tb_lu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [1:0]        req_vld, req_rdy, rsp_vld, rsp_rdy;
   logic [1:0][15:0]  req_a, req_b;
   logic [1:0][2:0]   req_op;
   logic [1:0][31:0]  rsp_dat;
   logic [1:0][4:0]   rsp_flg;
   logic [15:0]       lu_a, lu_b, op_cnt;
   logic [2:0]        lu_op;
   logic [31:0]       lu_out;
   logic [4:0]        lu_flg;
   logic              busy;

   logic [1:0]        p_req_vld, p_req_rdy, p_rsp_vld, p_rsp_rdy;
   logic [1:0][31:0]  p_rsp_dat;
   logic [1:0][4:0]   p_rsp_flg;
   logic [15:0]       p_lu_a, p_lu_b, p_op_cnt;
   logic [2:0]        p_lu_op;
   logic [31:0]       p_lu_out;
   logic [4:0]        p_lu_flg;
   logic              p_busy;

   // Shared logic unit: result in [15:0], opcode tagged in [31:29].
   function automatic logic [36:0] lu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
      logic [15:0] r;
      case (op)
         3'd0:    r = a & b;
         3'd1:    r = a | b;
         3'd2:    r = a ^ b;
         3'd3:    r = ~(a & b);
         3'd4:    r = ~(a | b);
         3'd5:    r = ~(a ^ b);
         3'd6:    r = ~a;
         default: r = a;
      endcase
      return {a == 16'h0, b == 16'h0, a == b, a > b, a < b, op, 13'h0, r};
   endfunction

   assign {lu_flg, lu_out}     = lu_model(lu_a, lu_b, lu_op);
   assign {p_lu_flg, p_lu_out} = lu_model(p_lu_a, p_lu_b, p_lu_op);

   lu_arbiter #(.ARB_MODE(0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req_vld[0]), .req0_ready(req_rdy[0]),
      .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
      .req1_valid(req_vld[1]), .req1_ready(req_rdy[1]),
      .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
      .rsp0_valid(rsp_vld[0]), .rsp0_ready(rsp_rdy[0]),
      .rsp0_data(rsp_dat[0]), .rsp0_flags(rsp_flg[0]),
      .rsp1_valid(rsp_vld[1]), .rsp1_ready(rsp_rdy[1]),
      .rsp1_data(rsp_dat[1]), .rsp1_flags(rsp_flg[1]),
      .lu_a(lu_a), .lu_b(lu_b), .lu_opcode(lu_op), .lu_outlu(lu_out),
      .lu_za(lu_flg[4]), .lu_zb(lu_flg[3]), .lu_eq(lu_flg[2]),
      .lu_gt(lu_flg[1]), .lu_lt(lu_flg[0]),
      .busy(busy), .op_count(op_cnt)
   );

   lu_arbiter #(.ARB_MODE(1), .OPCNT_RST(16'hFFFD)) dut_pri (
      .clk(clk), .rst(rst),
      .req0_valid(p_req_vld[0]), .req0_ready(p_req_rdy[0]),
      .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
      .req1_valid(p_req_vld[1]), .req1_ready(p_req_rdy[1]),
      .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
      .rsp0_valid(p_rsp_vld[0]), .rsp0_ready(p_rsp_rdy[0]),
      .rsp0_data(p_rsp_dat[0]), .rsp0_flags(p_rsp_flg[0]),
      .rsp1_valid(p_rsp_vld[1]), .rsp1_ready(p_rsp_rdy[1]),
      .rsp1_data(p_rsp_dat[1]), .rsp1_flags(p_rsp_flg[1]),
      .lu_a(p_lu_a), .lu_b(p_lu_b), .lu_opcode(p_lu_op), .lu_outlu(p_lu_out),
      .lu_za(p_lu_flg[4]), .lu_zb(p_lu_flg[3]), .lu_eq(p_lu_flg[2]),
      .lu_gt(p_lu_flg[1]), .lu_lt(p_lu_flg[0]),
      .busy(p_busy), .op_count(p_op_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op);
      req_a[id]   = a;
      req_b[id]   = b;
      req_op[id]  = op;
      req_vld[id] = 1'b1;
   endtask

   // Called just after a falling edge; returns at the falling edge inside EXEC.
   task automatic accept(input int id, input string tag);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (req_rdy[id]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_rdy"}, 32'(ok), 32'd1);
      chk({tag, "_oth_rdy"}, 32'(req_rdy[1-id]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_vld[id] = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   // From EXEC: check the response, optionally stall it, then take it.
   task automatic respond(input int id, input logic [31:0] d, input logic [4:0] f,
                          input int hold, input string tag);
      logic [1:0] exp_v;
      exp_v = (id == 1) ? 2'b10 : 2'b01;
      chk({tag, "_exec_rdy"}, 32'(req_rdy), 32'd0);
      @(negedge clk);
      chk({tag, "_vld"}, 32'(rsp_vld), 32'(exp_v));
      chk({tag, "_dat"}, rsp_dat[id], d);
      chk({tag, "_flg"}, 32'(rsp_flg[id]), 32'(f));
      chk({tag, "_oth_dat"}, rsp_dat[1-id], 32'h0);
      for (int h = 0; h < hold; h++) begin
         rsp_rdy[1-id] = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_vld"}, 32'(rsp_vld), 32'(exp_v));
         chk({tag, "_hold_dat"}, rsp_dat[id], d);
         chk({tag, "_hold_flg"}, 32'(rsp_flg[id]), 32'(f));
         chk({tag, "_hold_rdy"}, 32'(req_rdy), 32'd0);
      end
      rsp_rdy[1-id] = 1'b0;
      rsp_rdy[id]   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_rdy[id] = 1'b0;
      chk({tag, "_done_vld"}, 32'(rsp_vld), 32'd0);
      chk({tag, "_done_dat"}, rsp_dat[id], d);
   endtask

   logic [15:0] exp_cnt [4];

   initial begin
      exp_cnt   = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      rst       = 1'b1;
      req_vld   = 2'b00;
      rsp_rdy   = 2'b00;
      p_req_vld = 2'b00;
      p_rsp_rdy = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      repeat (2) @(negedge clk);

      req_vld   = 2'b11;
      p_req_vld = 2'b11;
      #1;
      chk("rst_rdy", 32'(req_rdy), 32'd0);
      chk("rst_p_rdy", 32'(p_req_rdy), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(op_cnt), 32'd0);
      chk("rst_lu", {lu_a, lu_b}, 32'h0);
      chk("rst_luop", 32'(lu_op), 32'd0);
      chk("rst_rvld", 32'(rsp_vld), 32'd0);
      chk("rst_dat0", rsp_dat[0], 32'h0);
      chk("rst_flg0", 32'(rsp_flg[0]), 32'd0);
      chk("rst_p_cnt", 32'(p_op_cnt), 32'h0000_FFFD);
      req_vld   = 2'b00;
      p_req_vld = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // Single request
      issue(0, 16'h0009, 16'h0005, 3'd0);
      accept(0, "single");
      chk("single_lu", {lu_a, lu_b}, 32'h0009_0005);
      chk("single_luop", 32'(lu_op), 32'd0);
      respond(0, 32'h0000_0001, 5'b00010, 0, "single");
      chk("single_cnt", 32'(op_cnt), 32'd1);
      chk("single_idle", 32'(busy), 32'd0);

      // Tie after reset, round-robin alternation, backpressure, zero flags
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_cnt", 32'(op_cnt), 32'd0);
      issue(0, 16'h0003, 16'h000F, 3'd1);
      issue(1, 16'h00E9, 16'h00E9, 3'd2);
      accept(0, "tie_first");
      respond(0, 32'h2000_000F, 5'b00001, 0, "tie_first");
      issue(0, 16'h0000, 16'h0000, 3'd3);
      accept(1, "rr1");
      respond(1, 32'h4000_0000, 5'b00100, 5, "bp1");
      issue(1, 16'h0000, 16'h0005, 3'd4);
      #1;
      chk("bp_reidle_rdy", 32'(req_rdy), 32'd1);
      accept(0, "zero");
      respond(0, 32'h6000_FFFF, 5'b11100, 0, "zero");
      accept(1, "za_lt");
      respond(1, 32'h8000_FFFA, 5'b10001, 0, "za_lt");
      chk("rr_cnt", 32'(op_cnt), 32'd4);

      // Reset while a response is pending
      issue(0, 16'h0007, 16'h0007, 3'd5);
      accept(0, "rstm");
      @(negedge clk);
      chk("rstm_vld", 32'(rsp_vld), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstm_vld_clr", 32'(rsp_vld), 32'd0);
      chk("rstm_cnt", 32'(op_cnt), 32'd0);
      chk("rstm_busy", 32'(busy), 32'd0);
      issue(1, 16'h1234, 16'h00FF, 3'd6);
      accept(1, "post");
      respond(1, 32'hC000_EDCB, 5'b00010, 0, "post");
      chk("post_cnt", 32'(op_cnt), 32'd1);

      // Fixed priority with both requesters always valid; op_count wraps
      req_a[0]  = 16'h00F0; req_b[0] = 16'h0F00; req_op[0] = 3'd7;
      req_a[1]  = 16'h0001; req_b[1] = 16'h0001; req_op[1] = 3'd0;
      p_req_vld = 2'b11;
      p_rsp_rdy = 2'b11;
      for (int i = 0; i < 4; i++) begin
         for (int n = 0; n < 10; n++) begin
            #1;
            if (p_req_rdy[0]) break;
            @(negedge clk);
         end
         chk("pri_rdy", 32'(p_req_rdy), 32'd1);
         @(posedge clk);
         @(negedge clk);
         chk("pri_lu", {p_lu_a, p_lu_b}, 32'h00F0_0F00);
         chk("pri_luop", 32'(p_lu_op), 32'd7);
         chk("pri_busy", 32'(p_busy), 32'd1);
         @(negedge clk);
         chk("pri_vld", 32'(p_rsp_vld), 32'd1);
         chk("pri_dat", p_rsp_dat[0], 32'hE000_00F0);
         chk("pri_flg", 32'(p_rsp_flg[0]), 32'(5'b00001));
         chk("pri_oth", {p_rsp_dat[1][26:0], p_rsp_flg[1]}, 32'h0);
         @(posedge clk);
         @(negedge clk);
         chk("pri_cnt", 32'(p_op_cnt), 32'(exp_cnt[i]));
      end
      p_req_vld = 2'b00;
      p_rsp_rdy = 2'b00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
